// File: rtl/wb_serial_burst_gen.sv
// wb_serial_burst_gen
//   Wishbone classic slave that streams a burst of DATA_W-bit words on N_CH
//   parallel serial lanes sharing one programmable bit period.
//
//   Registers (ADR_I[3:2]):
//     0 CTRL  W: [0] start, [1] msb_first, [2] abort
//             R: [1] msb_first, [8] busy, [31:16] words remaining
//     1 DIV   bit period = DIV+1 clocks
//     2 COUNT words per lane per burst
//     3 SEED  low DATA_W bits = initial word
//
//   Ports:
//     CLK_I, RST_I             clock, synchronous active-high reset
//     CYC_I/STB_I/WE_I/ADR_I/DAT_I/DAT_O/ACK_O  Wishbone classic slave
//     ena_o[N_CH]              per-lane frame strobe (0 = burst active)
//     data_o[N_CH]             per-lane serial data
//     busy_o                   burst in progress
module wb_serial_burst_gen #(
  parameter int DATA_W = 10,
  parameter int N_CH   = 2,
  parameter int DIV_W  = 16,
  parameter int CNT_W  = 16,
  parameter int ADR_W  = 32
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             CYC_I,
  input  logic             STB_I,
  input  logic             WE_I,
  input  logic [ADR_W-1:0] ADR_I,
  input  logic [31:0]      DAT_I,
  output logic [31:0]      DAT_O,
  output logic             ACK_O,
  output logic [N_CH-1:0]  ena_o,
  output logic [N_CH-1:0]  data_o,
  output logic             busy_o
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state_q;
  // programmed registers
  logic                msb_q;
  logic [DIV_W-1:0]    div_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   seed_q;
  // values latched for the running burst
  logic                run_msb_q;
  logic [DIV_W-1:0]    run_div_q;
  logic [CNT_W-1:0]    rem_q;
  logic [DATA_W-1:0]   base_q;     // lane-0 word; lane k sends base_q + k
  logic [DIV_W-1:0]    bit_cnt_q;
  logic [IDX_W-1:0]    bit_idx_q;

  logic                req, wr, rd, ctrl_wr, abort_go, start_go;
  logic                last_bit, word_end, burst_end;
  logic [IDX_W-1:0]    idx_nxt, sel_idx;
  logic [DATA_W-1:0]   base_nxt, sel_base;
  logic                sel_msb;
  logic [N_CH-1:0]     data_nxt;
  logic [31:0]         rdata, rem_ext;
  logic                unused_ok;

  always_comb begin
    req      = CYC_I & STB_I & ~ACK_O;
    wr       = req & WE_I;
    rd       = req & ~WE_I;
    ctrl_wr  = wr && (ADR_I[3:2] == 2'd0);
    abort_go = ctrl_wr & DAT_I[2];
    // abort in the same write suppresses start
    start_go = ctrl_wr & DAT_I[0] & ~DAT_I[2] & (state_q == IDLE) & (cnt_q != '0);

    last_bit  = (bit_cnt_q == '0);
    word_end  = last_bit && (bit_idx_q == IDX_W'(DATA_W-1));
    burst_end = word_end && (rem_q == CNT_W'(1));

    idx_nxt  = word_end ? '0 : (last_bit ? bit_idx_q + IDX_W'(1) : bit_idx_q);
    base_nxt = word_end ? base_q + DATA_W'(N_CH) : base_q;

    // outputs are registered, so present the bit that will be current
    // after this edge: the first bit on start, else the advanced position
    sel_base = start_go ? seed_q  : base_nxt;
    sel_idx  = start_go ? '0      : idx_nxt;
    sel_msb  = start_go ? DAT_I[1] : run_msb_q;
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    logic [DATA_W-1:0] word;
    logic [IDX_W-1:0]  pos;
    assign word        = sel_base + DATA_W'(k);
    assign pos         = sel_msb ? IDX_W'(DATA_W-1) - sel_idx : sel_idx;
    assign data_nxt[k] = word[pos];
  end

  always_comb begin
    rem_ext = 32'(rem_q);
    rdata   = '0;
    case (ADR_I[3:2])
      2'd0: rdata = {rem_ext[15:0], 7'd0, busy_o, 6'd0, msb_q, 1'b0};
      2'd1: rdata = 32'(div_q);
      2'd2: rdata = 32'(cnt_q);
      default: rdata = 32'(seed_q);
    endcase
  end

  assign unused_ok = ^{ADR_I, DAT_I, rem_ext};

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q   <= IDLE;
      ACK_O     <= 1'b0;
      DAT_O     <= '0;
      ena_o     <= '1;
      data_o    <= '0;
      busy_o    <= 1'b0;
      msb_q     <= 1'b0;
      div_q     <= DIV_W'(3);
      cnt_q     <= '0;
      seed_q    <= '0;
      run_msb_q <= 1'b0;
      run_div_q <= '0;
      rem_q     <= '0;
      base_q    <= '0;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
    end else begin
      ACK_O <= req;
      DAT_O <= rd ? rdata : '0;

      if (wr) begin
        case (ADR_I[3:2])
          2'd0: msb_q  <= DAT_I[1];
          2'd1: div_q  <= DAT_I[DIV_W-1:0];
          2'd2: cnt_q  <= DAT_I[CNT_W-1:0];
          default: seed_q <= DAT_I[DATA_W-1:0];
        endcase
      end

      case (state_q)
        IDLE: begin
          if (start_go) begin
            state_q   <= SHIFT;
            ena_o     <= '0;
            busy_o    <= 1'b1;
            data_o    <= data_nxt;
            run_msb_q <= DAT_I[1];
            run_div_q <= div_q;
            rem_q     <= cnt_q;
            base_q    <= seed_q;
            bit_cnt_q <= div_q;
            bit_idx_q <= '0;
          end
        end
        SHIFT: begin
          if (abort_go || burst_end) begin
            state_q <= IDLE;
            ena_o   <= '1;
            data_o  <= '0;
            busy_o  <= 1'b0;
            rem_q   <= '0;
          end else begin
            data_o    <= data_nxt;
            base_q    <= base_nxt;
            bit_idx_q <= idx_nxt;
            bit_cnt_q <= last_bit ? run_div_q : bit_cnt_q - DIV_W'(1);
            if (word_end) rem_q <= rem_q - CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_serial_burst_gen.sv
module tb_wb_serial_burst_gen;
  localparam int DATA_W = 10;
  localparam int N_CH   = 2;

  logic              CLK_I = 1'b0;
  logic              RST_I = 1'b1;
  logic              CYC_I = 1'b0, STB_I = 1'b0, WE_I = 1'b0;
  logic [31:0]       ADR_I = '0, DAT_I = '0;
  logic [31:0]       DAT_O;
  logic              ACK_O;
  logic [N_CH-1:0]   ena_o, data_o;
  logic              busy_o;

  wb_serial_burst_gen #(.DATA_W(DATA_W), .N_CH(N_CH), .DIV_W(16), .CNT_W(16), .ADR_W(32)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .CYC_I(CYC_I), .STB_I(STB_I), .WE_I(WE_I),
    .ADR_I(ADR_I), .DAT_I(DAT_I), .DAT_O(DAT_O), .ACK_O(ACK_O),
    .ena_o(ena_o), .data_o(data_o), .busy_o(busy_o)
  );

  always #5 CLK_I = ~CLK_I;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;
  logic [N_CH-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // expected per-clock lane data for one burst, straight from the word formula
  task automatic push_burst(input int div, input int cnt, input int seed, input bit msb);
    logic [DATA_W-1:0] w;
    logic [N_CH-1:0]   v;
    for (int i = 0; i < cnt; i++)
      for (int b = 0; b < DATA_W; b++) begin
        for (int k = 0; k < N_CH; k++) begin
          w    = DATA_W'((seed + i*N_CH + k) % (1 << DATA_W));
          v[k] = w[msb ? DATA_W-1-b : b];
        end
        for (int r = 0; r <= div; r++) exp_q.push_back(v);
      end
  endtask

  // called at a negedge; returns at a negedge with the bus idle again
  task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     output logic [31:0] rdat);
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = we; ADR_I = adr; DAT_I = dat;
    @(negedge CLK_I);
    chk("ack one cycle after request", 32'(ACK_O), 32'd1);
    rdat = DAT_O;
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
    @(negedge CLK_I);
    chk("ack single cycle", 32'(ACK_O), 32'd0);
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] d;
    bus(1'b1, adr, dat, d);
  endtask

  task automatic rd(input string name, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] d;
    bus(1'b0, adr, 32'd0, d);
    chk(name, d, exp);
  endtask

  task automatic chk_idle(input string name);
    chk({name, " ena"},  32'(ena_o),  32'(2'b11));
    chk({name, " busy"}, 32'(busy_o), 32'd0);
    chk({name, " data"}, 32'(data_o), 32'd0);
  endtask

  // every clock with a frame active must match the next scoreboard entry
  always @(negedge CLK_I) begin
    if (mon_en && (ena_o != '1 || busy_o != 1'b0)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected burst activity", {29'd0, busy_o, ena_o}, 32'(3'b011));
      end else begin
        chk("burst frame", {29'd0, busy_o, ena_o}, 32'(3'b100));
        chk("burst data", 32'(data_o), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic drain(input string name, input int budget);
    for (int c = 0; c < budget && exp_q.size() != 0; c++) begin
      @(negedge CLK_I); #1;
    end
    chk({name, " words left in scoreboard"}, 32'(exp_q.size()), 32'd0);
    @(negedge CLK_I);
    chk_idle({name, " end"});
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #2000000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    vecs.push_back('{1'b0, 32'h0,         32'h0,         32'h0,   "reset CTRL"});
    vecs.push_back('{1'b0, 32'h4,         32'h0,         32'h3,   "reset DIV"});
    vecs.push_back('{1'b0, 32'h8,         32'h0,         32'h0,   "reset COUNT"});
    vecs.push_back('{1'b0, 32'hC,         32'h0,         32'h0,   "reset SEED"});
    vecs.push_back('{1'b1, 32'h4,         32'h3,         32'h0,   ""});
    vecs.push_back('{1'b1, 32'h8,         32'h4,         32'h0,   ""});
    vecs.push_back('{1'b1, 32'hC,         32'hFFFF_F201, 32'h0,   ""});
    vecs.push_back('{1'b0, 32'h14,        32'h0,         32'h3,   "DIV via aliased address"});
    vecs.push_back('{1'b0, 32'h1000_0009, 32'h0,         32'h4,   "COUNT with high/low addr bits"});
    vecs.push_back('{1'b0, 32'hC,         32'h0,         32'h201, "SEED truncated to DATA_W"});

    // reset state
    repeat (3) @(negedge CLK_I);
    chk_idle("in reset");
    chk("reset ACK", 32'(ACK_O), 32'd0);
    chk("reset DAT_O", DAT_O, 32'd0);
    RST_I = 1'b0;
    mon_en = 1'b1;
    @(negedge CLK_I);

    // register table
    foreach (vecs[i]) begin
      logic [31:0] d;
      bus(vecs[i].we, vecs[i].adr, vecs[i].dat, d);
      if (!vecs[i].we) chk(vecs[i].name, d, vecs[i].exp);
    end

    // basic LSB-first burst, 4 words x 10 bits x 4 clocks = 160 clocks
    push_burst(3, 4, 'h201, 1'b0);
    wr(32'h0, 32'h1);
    drain("burst 0x201", 400);

    // seed wrap mod 2^DATA_W
    wr(32'h8, 32'd2);
    wr(32'hC, 32'h3FF);
    push_burst(3, 2, 'h3FF, 1'b0);
    wr(32'h0, 32'h1);
    drain("burst wrap", 300);

    // MSB first, one clock per bit
    wr(32'h4, 32'd0);
    wr(32'h8, 32'd1);
    wr(32'hC, 32'h2AA);
    push_burst(0, 1, 'h2AA, 1'b1);
    wr(32'h0, 32'h3);
    drain("burst msb", 50);
    rd("CTRL msb_first readback", 32'h0, 32'h2);

    // mid-burst writes do not disturb the running burst; abort ends it
    wr(32'h0, 32'h0);
    wr(32'h4, 32'd3);
    wr(32'h8, 32'd4);
    wr(32'hC, 32'h0);
    push_burst(3, 4, 0, 1'b0);
    wr(32'h0, 32'h1);
    repeat (10) @(negedge CLK_I);
    wr(32'h4, 32'd9);
    wr(32'h0, 32'h1);
    rd("CTRL while busy", 32'h0, 32'h0004_0100);
    rd("DIV reads new value", 32'h4, 32'd9);
    repeat (12) @(negedge CLK_I);
    wr(32'h0, 32'h5);
    chk_idle("after abort");
    exp_q.delete();
    rd("CTRL after abort", 32'h0, 32'h0);

    // reset mid-burst
    wr(32'h4, 32'd3);
    wr(32'hC, 32'h5);
    push_burst(3, 4, 5, 1'b0);
    wr(32'h0, 32'h1);
    repeat (15) @(negedge CLK_I);
    RST_I = 1'b1;
    @(negedge CLK_I);
    chk_idle("reset mid-burst");
    chk("reset mid-burst ACK", 32'(ACK_O), 32'd0);
    exp_q.delete();
    RST_I = 1'b0;
    @(negedge CLK_I);
    rd("COUNT after reset", 32'h8, 32'd0);
    wr(32'h0, 32'h1);
    repeat (30) @(negedge CLK_I);
    chk_idle("start with COUNT=0");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
